tmr_lane_controller: RTL and testbench
======================================

# tmr_lane_controller

Triple-modular-redundancy controller for the RISC-V core. Sits between three replicated core lanes and the shared instruction/data memories. Majority-votes each lane's external bundle every cycle, tracks per-lane disagreement, and masks a persistently faulty lane by holding it in reset. Degrades TMR to duplex compare and halts the system on an uncorrectable disagreement.

## Interface

- `WIDTH`, default 32: width of the PC, ALU result and store-data fields.
- `STRIKE_LIMIT`, default 3: number of consecutive disagreeing cycles before a lane is masked. Legal range is 1..15.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. Synchronous and active-low.
- `pc_a`, `pc_b`, `pc_c`, input, WIDTH each: PC of lanes 0, 1 and 2.
- `alu_a`, `alu_b`, `alu_c`, input, WIDTH each: ALU result (data address) of each lane.
- `rd2_a`, `rd2_b`, `rd2_c`, input, WIDTH each: store data of each lane.
- `mw_a`, `mw_b`, `mw_c`, input, 1 each: MemWrite of each lane.
- `pc_v`, `alu_v`, `rd2_v`, output, WIDTH each: voted PC, address and store data.
- `mw_v`, output, 1: voted MemWrite, after suppression.
- `core_rst_n`, output, 3: per-lane core reset. Synchronous, active-low.
- `lane_mask`, output, 3: masked lanes; bit i corresponds to lane i.
- `mode`, output, 2: 00 TMR, 01 DEGRADED, 10 FAIL.
- `halt`, output, 1: asserted while in FAIL.
- `err_count`, output, 16: saturating count of cycles with any lane disagreement.

## Operation

- **Bundle and disagreement.**
  - Bundle of lane i is {pc, alu, rd2, mw}, 3*WIDTH+1 bits.
  - `dis[i]` = lane i's bundle differs from the voted bundle. Unmasked lanes only.
- **TMR state.**
  - Voted outputs are the bitwise 2-of-3 majority.
  - If exactly one lane has `dis`, that lane's strike counter increments and the other strike counters clear.
  - If no lane has `dis`, all strike counters clear.
  - When a strike counter reaches STRIKE_LIMIT, set that lane's `lane_mask` bit, clear its counter, and go to DEGRADED.
  - If two or more lanes have `dis` in the same cycle, there is no consensus: go to FAIL.
- **DEGRADED state.**
  - Voted outputs come from the lowest-index unmasked lane.
  - If the two unmasked bundles differ, go to FAIL.
  - Strike counters are idle.
- **FAIL state.**
  - Terminal; the only exit is `rst`.
  - `halt`=1 and `mw_v`=0.
  - `core_rst_n`=000.
  - Voted outputs hold the lowest-index unmasked lane value.
- **Write suppression (combinational, same cycle).**
  - `mw_v` is forced to 0 in any cycle whose state or condition leads to FAIL (no-consensus in TMR, pair mismatch in DEGRADED).
  - `mw_v` is also 0 whenever the current state is FAIL.
- **Core resets.** `core_rst_n[i]` = `rst` & ~`lane_mask[i]` & (mode != FAIL).
- **Error counter.** `err_count` increments by 1 in every cycle where any unmasked lane disagrees. It saturates at 0xFFFF.
- **Priority.** When masking and no-consensus occur in the same cycle, FAIL wins. `lane_mask` is not updated in that case.
- **Mask lifetime.** A masked lane stays masked until `rst`. At most one lane is ever masked.

## Timing

- **Voted outputs.** `pc_v`, `alu_v`, `rd2_v` and `mw_v` are combinational from the lane inputs and registered state, with zero latency. This is required by the single-cycle core's memory access.
- **State updates.** `mode`, `lane_mask`, the strike counters and `err_count` update on the rising `clk` edge.
- **Masking latency.** A lane is masked at the edge ending the STRIKE_LIMIT-th consecutive disagreeing cycle. Its `core_rst_n` drops in the same cycle as its `lane_mask` bit.
- **FAIL latency.** FAIL is entered at the edge ending the offending cycle. `halt` and `core_rst_n`=000 appear in the next cycle. `mw_v` is already 0 in the offending cycle.
- **Reset state.** With `rst`=0 sampled at an edge, the registered state is:
  - `mode`=00, `lane_mask`=000, strike counters 0, `err_count`=0, `halt`=0.
  - `core_rst_n`=000 during reset, because it follows `rst`.
- **Reset mid-operation.** Reset applies from any state, including FAIL and DEGRADED, on the next edge.

## Configuration

- **`TMR_STRIKE_FILTER_EN` defined:** strike counters exist and masking requires STRIKE_LIMIT consecutive single-lane disagreements.
- **`TMR_STRIKE_FILTER_EN` undefined:**
  - No strike counters; STRIKE_LIMIT is ignored.
  - A lane is masked at the edge ending its first single-lane disagreement cycle.
  - All other behaviour is identical.

## Test plan

- **Clean run.** Identical lanes for 100 cycles (pc 0x0, 0x4, …) -> `mode`=00, `lane_mask`=000, `err_count`=0, and voted outputs equal lane values every cycle.
- **Transient upset.** Lane 1 alu differs for 2 cycles, then agrees (STRIKE_LIMIT=3) -> no mask and `err_count`=2. `alu_v` equals the lane 0/2 value during the upset.
- **Persistent fault.** Lane 2 pc=0x44 vs 0x40 for 3 cycles -> `lane_mask`=100, `mode`=01 and `core_rst_n`=011 after the 3rd edge. `pc_v`=0x40 throughout.
- **Duplex break.** In DEGRADED with lane 2 masked, lane 0 `mw`=1 and lane 1 `mw`=0 -> `mw_v`=0 that cycle; next cycle `mode`=10, `halt`=1, `core_rst_n`=000.
- **No consensus.** Lanes 1 and 2 both disagree with the vote in one cycle with `mw_a`=1 -> `mw_v`=0 that cycle, then FAIL. Applying `rst`=0 for one edge returns `mode`=00, `lane_mask`=000, `err_count`=0.
- **Filter off.** With `TMR_STRIKE_FILTER_EN` undefined, a single-cycle lane 0 mismatch -> `lane_mask`=001 and `mode`=01 after that edge.

Source files
------------

// File: rtl/tmr_lane_controller.sv
// Triple-modular-redundancy controller: votes three core lanes, masks a faulty lane, halts on lost consensus.
// Optional strike filter enabled by defining TMR_STRIKE_FILTER_EN.
module tmr_lane_controller #(
  parameter int WIDTH        = 32,
  parameter int STRIKE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_a,
  input  logic [WIDTH-1:0] pc_b,
  input  logic [WIDTH-1:0] pc_c,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [WIDTH-1:0] rd2_a,
  input  logic [WIDTH-1:0] rd2_b,
  input  logic [WIDTH-1:0] rd2_c,
  input  logic             mw_a,
  input  logic             mw_b,
  input  logic             mw_c,
  output logic [WIDTH-1:0] pc_v,
  output logic [WIDTH-1:0] alu_v,
  output logic [WIDTH-1:0] rd2_v,
  output logic             mw_v,
  output logic [2:0]       core_rst_n,
  output logic [2:0]       lane_mask,
  output logic [1:0]       mode,
  output logic             halt,
  output logic [15:0]      err_count
);

  localparam int BW = 3 * WIDTH + 1;

  typedef enum logic [1:0] {
    MODE_TMR      = 2'b00,
    MODE_DEGRADED = 2'b01,
    MODE_FAIL     = 2'b10
  } mode_t;

  mode_t         state_q, state_d;
  logic [2:0]    mask_q, mask_d;
  logic [15:0]   err_q;
  logic [BW-1:0] b0, b1, b2, maj, sel, voted;
  logic [2:0]    dis, mask_hit;
  logic          single, multi, go_fail;

  assign b0  = {pc_a, alu_a, rd2_a, mw_a};
  assign b1  = {pc_b, alu_b, rd2_b, mw_b};
  assign b2  = {pc_c, alu_c, rd2_c, mw_c};
  assign maj = (b0 & b1) | (b0 & b2) | (b1 & b2);
  // At most one lane is ever masked, so lane 0 is the reference unless it is the masked one
  assign sel   = mask_q[0] ? b1 : b0;
  assign voted = (state_q == MODE_TMR) ? maj : sel;

  assign dis[0] = ~mask_q[0] & (b0 != voted);
  assign dis[1] = ~mask_q[1] & (b1 != voted);
  assign dis[2] = ~mask_q[2] & (b2 != voted);

  assign single = (dis == 3'b001) || (dis == 3'b010) || (dis == 3'b100);
  assign multi  = (dis != 3'b000) && !single;

`ifdef TMR_STRIKE_FILTER_EN
  localparam logic [3:0] LIMIT_M1 = 4'(STRIKE_LIMIT - 1);

  logic [3:0] strike_q [3];

  always_comb begin
    mask_hit = 3'b000;
    for (int i = 0; i < 3; i++)
      mask_hit[i] = single && dis[i] && (strike_q[i] == LIMIT_M1);
  end

  // Consecutive single-lane disagreements only; counters freeze outside TMR
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) strike_q[i] <= 4'd0;
    end else if (state_q == MODE_TMR) begin
      for (int i = 0; i < 3; i++)
        strike_q[i] <= (single && dis[i] && !mask_hit[i]) ? strike_q[i] + 4'd1 : 4'd0;
    end
  end
`else
  // Without the filter any legal limit behaves as 1
  assign mask_hit = (single && STRIKE_LIMIT > 0) ? dis : 3'b000;
`endif

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    go_fail = 1'b0;
    case (state_q)
      MODE_TMR: begin
        if (multi) begin
          go_fail = 1'b1;
          state_d = MODE_FAIL;
        end else if (mask_hit != 3'b000) begin
          mask_d  = mask_q | mask_hit;
          state_d = MODE_DEGRADED;
        end
      end
      MODE_DEGRADED: begin
        if (dis != 3'b000) begin
          go_fail = 1'b1;
          state_d = MODE_FAIL;
        end
      end
      MODE_FAIL: state_d = MODE_FAIL;
      default:   state_d = MODE_FAIL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MODE_TMR;
      mask_q  <= 3'b000;
      err_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      if (dis != 3'b000 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
    end
  end

  assign pc_v       = voted[3*WIDTH -: WIDTH];
  assign alu_v      = voted[2*WIDTH -: WIDTH];
  assign rd2_v      = voted[WIDTH -: WIDTH];
  assign mw_v       = voted[0] & ~go_fail & (state_q != MODE_FAIL);
  assign core_rst_n = {3{rst}} & ~mask_q & {3{state_q != MODE_FAIL}};
  assign lane_mask  = mask_q;
  assign mode       = state_q;
  assign halt       = (state_q == MODE_FAIL);
  assign err_count  = err_q;

endmodule

// File: tb/tb_tmr_lane_controller.sv
// Directed self-checking bench for tmr_lane_controller; expectations adapt to TMR_STRIKE_FILTER_EN.
module tb_tmr_lane_controller;

`ifdef TMR_STRIKE_FILTER_EN
  localparam int MASK_EDGES = 3;
`else
  localparam int MASK_EDGES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_l [3];
  logic [31:0] alu_l [3];
  logic [31:0] rd2_l [3];
  logic        mw_l [3];
  logic [31:0] pc_v, alu_v, rd2_v;
  logic        mw_v, halt;
  logic [2:0]  core_rst_n, lane_mask;
  logic [1:0]  mode;
  logic [15:0] err_count;
  int          errors = 0;
  int          checks = 0;

  tmr_lane_controller #(.WIDTH(32), .STRIKE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .pc_a(pc_l[0]), .pc_b(pc_l[1]), .pc_c(pc_l[2]),
    .alu_a(alu_l[0]), .alu_b(alu_l[1]), .alu_c(alu_l[2]),
    .rd2_a(rd2_l[0]), .rd2_b(rd2_l[1]), .rd2_c(rd2_l[2]),
    .mw_a(mw_l[0]), .mw_b(mw_l[1]), .mw_c(mw_l[2]),
    .pc_v(pc_v), .alu_v(alu_v), .rd2_v(rd2_v), .mw_v(mw_v),
    .core_rst_n(core_rst_n), .lane_mask(lane_mask), .mode(mode),
    .halt(halt), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int lane, input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] rd2, input logic mw);
    pc_l[lane]  = pc;
    alu_l[lane] = alu;
    rd2_l[lane] = rd2;
    mw_l[lane]  = mw;
  endtask

  task automatic set_all(input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic mw);
    for (int i = 0; i < 3; i++) applyStimulus(i, pc, alu, rd2, mw);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    set_all(32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_all(32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (mode !== 2'b00) begin errors++; $display("[TB] FAIL reset_mode: got %b expected 00", mode); end
    checks++; if (lane_mask !== 3'b000) begin errors++; $display("[TB] FAIL reset_mask: got %b expected 000", lane_mask); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_err: got %0d expected 0", err_count); end
    checks++; if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
    checks++; if (core_rst_n !== 3'b000) begin errors++; $display("[TB] FAIL reset_core_rst: got %b expected 000", core_rst_n); end
    rst = 1'b1;
    #1;
    checks++; if (core_rst_n !== 3'b111) begin errors++; $display("[TB] FAIL release_core_rst: got %b expected 111", core_rst_n); end
  endtask

  task automatic test_clean_run();
    int bad = 0;
    reset_dut();
    for (int i = 0; i < 100; i++) begin
      set_all(32'(i * 4), 32'(32'h1000 + i * 8), 32'(32'hA5A50000 ^ i), 1'(i % 2));
      if (pc_v !== 32'(i * 4) || alu_v !== 32'(32'h1000 + i * 8) ||
          rd2_v !== 32'(32'hA5A50000 ^ i) || mw_v !== 1'(i % 2)) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL clean_voted: got %0d bad cycles expected 0", bad); end
    checks++; if (mode !== 2'b00) begin errors++; $display("[TB] FAIL clean_mode: got %b expected 00", mode); end
    checks++; if (lane_mask !== 3'b000) begin errors++; $display("[TB] FAIL clean_mask: got %b expected 000", lane_mask); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("[TB] FAIL clean_err: got %0d expected 0", err_count); end
  endtask

  // Lane 1 alu upsets in a 1,1,0,1,1 pattern: the agreeing cycle must reset the strike count
  task automatic test_transient();
    logic [4:0] pattern;
    logic [2:0] exp_mask;
    logic [15:0] exp_err;
    pattern = 5'b11011;
    exp_mask = (MASK_EDGES == 1) ? 3'b010 : 3'b000;
    exp_err  = (MASK_EDGES == 1) ? 16'd1 : 16'd4;
    reset_dut();
    for (int k = 0; k < 5; k++) begin
      set_all(32'h100, 32'h2000, 32'h55, 1'b0);
      if (pattern[k]) applyStimulus(1, 32'h100, 32'h2F00, 32'h55, 1'b0);
      #1;
      checks++; if (alu_v !== 32'h2000) begin errors++; $display("[TB] FAIL transient_alu_v[%0d]: got %h expected 00002000", k, alu_v); end
      tick();
    end
    checks++; if (lane_mask !== exp_mask) begin errors++; $display("[TB] FAIL transient_mask: got %b expected %b", lane_mask, exp_mask); end
    checks++; if (err_count !== exp_err) begin errors++; $display("[TB] FAIL transient_err: got %0d expected %0d", err_count, exp_err); end
  endtask

  task automatic test_persistent_and_duplex();
    logic [2:0] exp_mask;
    logic [1:0] exp_mode;
    logic [15:0] exp_err;
    reset_dut();
    for (int k = 1; k <= 3; k++) begin
      set_all(32'h40, 32'h300, 32'h7, 1'b0);
      applyStimulus(2, 32'h44, 32'h300, 32'h7, 1'b0);
      #1;
      checks++; if (pc_v !== 32'h40) begin errors++; $display("[TB] FAIL persist_pc_v[%0d]: got %h expected 00000040", k, pc_v); end
      tick();
      exp_mask = (k >= MASK_EDGES) ? 3'b100 : 3'b000;
      exp_mode = (k >= MASK_EDGES) ? 2'b01 : 2'b00;
      checks++; if (lane_mask !== exp_mask) begin errors++; $display("[TB] FAIL persist_mask[%0d]: got %b expected %b", k, lane_mask, exp_mask); end
      checks++; if (mode !== exp_mode) begin errors++; $display("[TB] FAIL persist_mode[%0d]: got %b expected %b", k, mode, exp_mode); end
    end
    exp_err = 16'(MASK_EDGES);
    checks++; if (core_rst_n !== 3'b011) begin errors++; $display("[TB] FAIL persist_core_rst: got %b expected 011", core_rst_n); end
    checks++; if (err_count !== exp_err) begin errors++; $display("[TB] FAIL persist_err: got %0d expected %0d", err_count, exp_err); end
    // Duplex pair agrees while the masked lane wanders: no error, no FAIL
    set_all(32'h80, 32'h400, 32'h9, 1'b1);
    applyStimulus(2, 32'hDEAD, 32'h0, 32'h0, 1'b0);
    #1;
    checks++; if (pc_v !== 32'h80 || mw_v !== 1'b1) begin errors++; $display("[TB] FAIL degraded_vote: got pc %h mw %b expected pc 00000080 mw 1", pc_v, mw_v); end
    tick();
    checks++; if (mode !== 2'b01 || err_count !== exp_err) begin errors++; $display("[TB] FAIL degraded_hold: got mode %b err %0d expected mode 01 err %0d", mode, err_count, exp_err); end
    // Duplex break on MemWrite
    applyStimulus(0, 32'h84, 32'h404, 32'h9, 1'b1);
    applyStimulus(1, 32'h84, 32'h404, 32'h9, 1'b0);
    #1;
    checks++; if (mw_v !== 1'b0) begin errors++; $display("[TB] FAIL duplex_mw_v: got %b expected 0", mw_v); end
    tick();
    checks++; if (mode !== 2'b10) begin errors++; $display("[TB] FAIL duplex_mode: got %b expected 10", mode); end
    checks++; if (halt !== 1'b1) begin errors++; $display("[TB] FAIL duplex_halt: got %b expected 1", halt); end
    checks++; if (core_rst_n !== 3'b000) begin errors++; $display("[TB] FAIL duplex_core_rst: got %b expected 000", core_rst_n); end
    checks++; if (pc_v !== 32'h84) begin errors++; $display("[TB] FAIL fail_pc_v: got %h expected 00000084", pc_v); end
  endtask

  task automatic test_no_consensus();
    reset_dut();
    applyStimulus(0, 32'h3, 32'h0, 32'h0, 1'b1);
    applyStimulus(1, 32'h1, 32'h0, 32'h0, 1'b1);
    applyStimulus(2, 32'h2, 32'h0, 32'h0, 1'b1);
    #1;
    checks++; if (pc_v !== 32'h3) begin errors++; $display("[TB] FAIL nocons_pc_v: got %h expected 00000003", pc_v); end
    checks++; if (mw_v !== 1'b0) begin errors++; $display("[TB] FAIL nocons_mw_v: got %b expected 0", mw_v); end
    tick();
    checks++; if (mode !== 2'b10 || halt !== 1'b1) begin errors++; $display("[TB] FAIL nocons_mode: got mode %b halt %b expected mode 10 halt 1", mode, halt); end
    checks++; if (lane_mask !== 3'b000) begin errors++; $display("[TB] FAIL nocons_mask: got %b expected 000", lane_mask); end
    set_all(32'h8, 32'h8, 32'h8, 1'b1);
    checks++; if (mw_v !== 1'b0 || core_rst_n !== 3'b000) begin errors++; $display("[TB] FAIL fail_hold: got mw %b core_rst %b expected mw 0 core_rst 000", mw_v, core_rst_n); end
    tick();
    checks++; if (mode !== 2'b10) begin errors++; $display("[TB] FAIL fail_sticky: got %b expected 10", mode); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (mode !== 2'b00 || lane_mask !== 3'b000 || err_count !== 16'd0 || halt !== 1'b0) begin
      errors++; $display("[TB] FAIL fail_reset: got mode %b mask %b err %0d halt %b expected 00 000 0 0", mode, lane_mask, err_count, halt);
    end
    checks++; if (core_rst_n !== 3'b111 || mw_v !== 1'b1) begin errors++; $display("[TB] FAIL fail_reset_out: got core_rst %b mw %b expected 111 1", core_rst_n, mw_v); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) applyStimulus(i, 32'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_clean_run();
    test_transient();
    test_persistent_and_duplex();
    test_no_consensus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
